// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns active-low CPU read/write requests into timed external
// bus cycles (setup, strobe with wait states and wait extension, hold) and reports completion.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_WS   = 1,
  parameter int unsigned IO_WS    = 3,
  parameter logic [7:0]  IO_PAGE  = 8'hFF,
  parameter int unsigned WAIT_TMO = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_oe_mem,
  input  logic              n_we_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_out,
  output logic [DATA_W-1:0] d_in,
  output logic              n_mem_rdy,
  output logic              bus_err,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_do,
  output logic              ext_do_en,
  input  logic [DATA_W-1:0] ext_di,
  output logic              ext_n_cs_mem,
  output logic              ext_n_cs_io,
  output logic              ext_n_oe,
  output logic              ext_n_we,
  input  logic              ext_n_wait
);

  localparam int unsigned WS_W  = 4;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [WS_W-1:0]    ws_q, ws_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wr_q, wr_d;
  logic               io_q, io_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  do_d;
  logic [DATA_W-1:0]  din_d;
  logic               n_cs_mem_d, n_cs_io_d, n_oe_d, n_we_d, do_en_d, n_rdy_d, berr_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ws_q         <= '0;
      tmo_q        <= '0;
      wr_q         <= 1'b0;
      io_q         <= 1'b0;
      err_q        <= 1'b0;
      ext_addr     <= '0;
      ext_do       <= '0;
      d_in         <= '0;
      ext_n_cs_mem <= 1'b1;
      ext_n_cs_io  <= 1'b1;
      ext_n_oe     <= 1'b1;
      ext_n_we     <= 1'b1;
      ext_do_en    <= 1'b0;
      n_mem_rdy    <= 1'b1;
      bus_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_q         <= ws_d;
      tmo_q        <= tmo_d;
      wr_q         <= wr_d;
      io_q         <= io_d;
      err_q        <= err_d;
      ext_addr     <= addr_d;
      ext_do       <= do_d;
      d_in         <= din_d;
      ext_n_cs_mem <= n_cs_mem_d;
      ext_n_cs_io  <= n_cs_io_d;
      ext_n_oe     <= n_oe_d;
      ext_n_we     <= n_we_d;
      ext_do_en    <= do_en_d;
      n_mem_rdy    <= n_rdy_d;
      bus_err      <= berr_d;
    end
  end

  // Next state, latches and counters; outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    tmo_d   = tmo_q;
    wr_d    = wr_q;
    io_d    = io_q;
    err_d   = err_q;
    addr_d  = ext_addr;
    do_d    = ext_do;
    din_d   = d_in;

    unique case (state_q)
      ST_IDLE: begin
        if (!n_we_mem || !n_oe_mem) begin
          wr_d    = !n_we_mem;
          io_d    = (addr[ADDR_W-1 -: 8] == IO_PAGE);
          addr_d  = addr;
          do_d    = d_out;
          ws_d    = io_d ? WS_W'(IO_WS) : WS_W'(MEM_WS);
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (ws_q != '0) begin
          ws_d = WS_W'(ws_q - WS_W'(1));
        end else if (ext_n_wait) begin
          if (!wr_q) din_d = ext_di;
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_W'(WAIT_TMO)) begin
          // Peripheral held wait past its budget: finish without capturing data
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tmo_d = TMO_W'(tmo_q + TMO_W'(1));
        end
      end
      ST_HOLD:    state_d = ST_DONE;
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (n_oe_mem && n_we_mem) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    n_cs_mem_d = 1'b1;
    n_cs_io_d  = 1'b1;
    n_oe_d     = 1'b1;
    n_we_d     = 1'b1;
    do_en_d    = 1'b0;
    n_rdy_d    = 1'b1;
    berr_d     = 1'b0;

    unique case (state_d)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        n_cs_mem_d = io_d;
        n_cs_io_d  = !io_d;
        do_en_d    = wr_d;
        if (state_d == ST_STROBE) begin
          n_oe_d = wr_d;
          n_we_d = !wr_d;
        end
      end
      ST_DONE: begin
        n_rdy_d = 1'b0;
        berr_d  = err_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: bus timing, region decode, wait extension,
// timeout, request release handshake and reset abort.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_oe_mem, n_we_mem;
  logic [15:0] addr;
  logic [7:0]  d_out, d_in, ext_do, ext_di;
  logic        n_mem_rdy, bus_err, ext_do_en;
  logic [15:0] ext_addr;
  logic        ext_n_cs_mem, ext_n_cs_io, ext_n_oe, ext_n_we, ext_n_wait;

  int errors = 0;
  int checks = 0;

  int rdy_cyc, oe_low, we_low, csm_low, csio_low, den_cyc, ovl, cnt_a, cnt_b;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem), .addr(addr),
    .d_out(d_out), .d_in(d_in), .n_mem_rdy(n_mem_rdy), .bus_err(bus_err),
    .ext_addr(ext_addr), .ext_do(ext_do), .ext_do_en(ext_do_en), .ext_di(ext_di),
    .ext_n_cs_mem(ext_n_cs_mem), .ext_n_cs_io(ext_n_cs_io), .ext_n_oe(ext_n_oe),
    .ext_n_we(ext_n_we), .ext_n_wait(ext_n_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; cycle 1 is the first cycle after accept. Wait is low for cycles [wfrom, wfrom+wlen).
  task automatic access(input logic we_n, input logic oe_n, input logic [15:0] a,
                        input logic [7:0] d, input int wfrom, input int wlen);
    int cyc;
    cyc = 0; rdy_cyc = -1; oe_low = 0; we_low = 0; csm_low = 0; csio_low = 0; den_cyc = 0; ovl = 0;
    n_we_mem = we_n; n_oe_mem = oe_n; addr = a; d_out = d; ext_n_wait = 1'b1;
    while (rdy_cyc < 0 && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        addr  = ~a;
        d_out = ~d;
      end
      ext_n_wait = !(cyc >= wfrom && cyc < wfrom + wlen);
      if (!ext_n_oe)     oe_low++;
      if (!ext_n_we)     we_low++;
      if (!ext_n_cs_mem) csm_low++;
      if (!ext_n_cs_io)  csio_low++;
      if (ext_do_en)     den_cyc++;
      if ((!ext_n_cs_mem && !ext_n_cs_io) || (!ext_n_oe && !ext_n_we) ||
          ((!ext_n_oe || !ext_n_we) && ext_n_cs_mem && ext_n_cs_io)) ovl++;
      if (!n_mem_rdy) rdy_cyc = cyc;
    end
    ext_n_wait = 1'b1;
  endtask

  // Release requests; rdy must be a single-cycle pulse, then back to IDLE
  task automatic release_gap(input string tag);
    n_oe_mem = 1'b1;
    n_we_mem = 1'b1;
    tick();
    chk({tag, "_rdy_pulse"}, 32'(n_mem_rdy), 32'd1);
    chk({tag, "_err_clr"}, 32'(bus_err), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; n_oe_mem = 1'b1; n_we_mem = 1'b1; addr = '0; d_out = '0;
    ext_di = '0; ext_n_wait = 1'b1;
    repeat (3) tick();
    chk("rst_strobes", {28'd0, ext_n_cs_mem, ext_n_cs_io, ext_n_oe, ext_n_we}, 32'hF);
    chk("rst_rdy_err_en", {29'd0, n_mem_rdy, bus_err, ext_do_en}, 32'h4);
    chk("rst_data", {ext_addr, ext_do, d_in}, 32'h0);
    rst = 1'b0;
    tick();

    // 1: memory read, MEM_WS=1
    ext_di = 8'hA5;
    access(1'b1, 1'b0, 16'h1234, 8'h00, 0, 0);
    chk("t1_rdy_cyc", 32'(rdy_cyc), 32'd5);
    chk("t1_oe_low", 32'(oe_low), 32'd2);
    chk("t1_we_low", 32'(we_low), 32'd0);
    chk("t1_cs_mem", 32'(csm_low), 32'd4);
    chk("t1_cs_io", 32'(csio_low), 32'd0);
    chk("t1_do_en", 32'(den_cyc), 32'd0);
    chk("t1_overlap", 32'(ovl), 32'd0);
    chk("t1_d_in", 32'(d_in), 32'hA5);
    chk("t1_bus_err", 32'(bus_err), 32'd0);
    chk("t1_ext_addr", 32'(ext_addr), 32'h1234);
    release_gap("t1");

    // 2: I/O page write, IO_WS=3
    ext_di = 8'hEE;
    access(1'b0, 1'b1, 16'hFF10, 8'h3C, 0, 0);
    chk("t2_rdy_cyc", 32'(rdy_cyc), 32'd7);
    chk("t2_we_low", 32'(we_low), 32'd4);
    chk("t2_oe_low", 32'(oe_low), 32'd0);
    chk("t2_cs_io", 32'(csio_low), 32'd6);
    chk("t2_cs_mem", 32'(csm_low), 32'd0);
    chk("t2_do_en", 32'(den_cyc), 32'd6);
    chk("t2_overlap", 32'(ovl), 32'd0);
    chk("t2_ext_do", 32'(ext_do), 32'h3C);
    chk("t2_ext_addr", 32'(ext_addr), 32'hFF10);
    chk("t2_d_in_kept", 32'(d_in), 32'hA5);
    release_gap("t2");

    // 3: both requests low -> write only
    ext_di = 8'h99;
    access(1'b0, 1'b0, 16'h0040, 8'h5A, 0, 0);
    chk("t3_rdy_cyc", 32'(rdy_cyc), 32'd5);
    chk("t3_we_low", 32'(we_low), 32'd2);
    chk("t3_oe_low", 32'(oe_low), 32'd0);
    chk("t3_ext_do", 32'(ext_do), 32'h5A);
    chk("t3_d_in_kept", 32'(d_in), 32'hA5);
    release_gap("t3");

    // 4: read with wait low for 5 cycles after WS expiry
    ext_di = 8'h6C;
    access(1'b1, 1'b0, 16'h2000, 8'h00, 3, 5);
    chk("t4_rdy_cyc", 32'(rdy_cyc), 32'd10);
    chk("t4_oe_low", 32'(oe_low), 32'd7);
    chk("t4_bus_err", 32'(bus_err), 32'd0);
    chk("t4_d_in", 32'(d_in), 32'h6C);
    chk("t4_overlap", 32'(ovl), 32'd0);
    release_gap("t4");

    // 5: wait held low -> timeout after WAIT_TMO extension cycles
    ext_di = 8'h77;
    access(1'b1, 1'b0, 16'h2001, 8'h00, 3, 1000);
    chk("t5_rdy_cyc", 32'(rdy_cyc), 32'd260);
    chk("t5_oe_low", 32'(oe_low), 32'd257);
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    chk("t5_d_in_kept", 32'(d_in), 32'h6C);
    release_gap("t5");

    // 6a: request held low after DONE -> no second bus cycle
    ext_di = 8'h11;
    access(1'b1, 1'b0, 16'h0100, 8'h00, 0, 0);
    chk("t6a_rdy_cyc", 32'(rdy_cyc), 32'd5);
    chk("t6a_d_in", 32'(d_in), 32'h11);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ext_n_oe || !ext_n_cs_mem) cnt_a++;
      if (!n_mem_rdy) cnt_b++;
    end
    chk("t6a_extra_strobe", 32'(cnt_a), 32'd0);
    chk("t6a_extra_rdy", 32'(cnt_b), 32'd0);
    n_oe_mem = 1'b1;
    repeat (2) tick();

    // 6b: reset asserted during STROBE aborts with no rdy pulse
    ext_di = 8'h33;
    n_oe_mem = 1'b0; addr = 16'h0300;
    tick();
    tick();
    chk("t6b_in_strobe", {30'd0, ext_n_oe, ext_n_cs_mem}, 32'd0);
    rst = 1'b1;
    tick();
    chk("t6b_rst_strobes", {28'd0, ext_n_cs_mem, ext_n_cs_io, ext_n_oe, ext_n_we}, 32'hF);
    chk("t6b_rst_rdy", 32'(n_mem_rdy), 32'd1);
    chk("t6b_rst_data", {ext_addr, ext_do, d_in}, 32'h0);
    rst = 1'b0; n_oe_mem = 1'b1;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!n_mem_rdy) cnt_b++;
    end
    chk("t6b_no_rdy", 32'(cnt_b), 32'd0);

    // Recovery read after reset abort
    ext_di = 8'h42;
    access(1'b1, 1'b0, 16'h0500, 8'h00, 0, 0);
    chk("t7_rdy_cyc", 32'(rdy_cyc), 32'd5);
    chk("t7_d_in", 32'(d_in), 32'h42);
    release_gap("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
